gcd_stream: RTL and testbench

//  Parametrised, handshaked GCD engine using Stein's binary algorithm (shift/subtract, no divider).

---
 rtl/gcd_pkg.sv | 17 +
 rtl/gcd_step.sv | 29 ++
 rtl/gcd_stream.sv | 134 +++++++++++++
 tb/tb_gcd_stream.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared types and helpers for the streaming binary-GCD engine.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STRIP = 3'd1,
        NORM  = 3'd2,
        LOOP  = 3'd3,
        DONE  = 3'd4
    } gcd_state_t;

    // Worst-case accept-to-result cycle count for a given operand width.
    function automatic int gcd_lat_max(input int w);
        return 4 * w + 4;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One combinational iteration of the Stein loop on an odd ra and arbitrary rb.
module gcd_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    output logic [WIDTH-1:0] ra_next,
    output logic [WIDTH-1:0] rb_next,
    output logic             rb_zero
);

    // ra is kept odd, so swapping on ra>rb keeps both subtractions non-negative.
    always_comb begin
        rb_zero = (rb == '0);
        ra_next = ra;
        rb_next = rb;
        if (!rb_zero) begin
            if (!rb[0]) begin
                rb_next = rb >> 1;
            end else if (ra > rb) begin
                ra_next = rb;
                rb_next = ra - rb;
            end else begin
                rb_next = rb - ra;
            end
        end
    end

endmodule

// File: rtl/gcd_stream.sv
// Handshaked, width-generic binary GCD engine with per-operation cycle count.
module gcd_stream
    import gcd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(gcd_lat_max(WIDTH) + 4)
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] return_val,
    output logic [CNT_W-1:0] cycles,
    output logic             busy
);

    localparam int K_W = $clog2(WIDTH + 1);

    gcd_state_t       state;
    gcd_state_t       state_next;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [K_W-1:0]   k;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] ra_next;
    logic [WIDTH-1:0] rb_next;
    logic             rb_zero;
    logic             accept;
    logic             zero_operand;

    assign accept       = in_valid && in_ready;
    assign zero_operand = (a == '0) || (b == '0);

    gcd_step #(.WIDTH(WIDTH)) u_step (
        .ra      (ra),
        .rb      (rb),
        .ra_next (ra_next),
        .rb_next (rb_next),
        .rb_zero (rb_zero)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = zero_operand ? DONE : STRIP;
            STRIP:   if (ra[0] | rb[0]) state_next = NORM;
            NORM:    if (ra[0]) state_next = LOOP;
            LOOP:    if (rb_zero) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // Results and the cycle count are captured once and held until the consumer takes them.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ra         <= '0;
            rb         <= '0;
            k          <= '0;
            cnt        <= '0;
            return_val <= '0;
            cycles     <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (zero_operand) begin
                            return_val <= a | b;
                            cycles     <= CNT_W'(1);
                            out_valid  <= 1'b1;
                        end else begin
                            ra  <= a;
                            rb  <= b;
                            k   <= '0;
                            cnt <= CNT_W'(1);
                        end
                    end
                end
                STRIP: begin
                    cnt <= cnt + 1'b1;
                    if (!(ra[0] | rb[0])) begin
                        ra <= ra >> 1;
                        rb <= rb >> 1;
                        k  <= k + 1'b1;
                    end
                end
                NORM: begin
                    cnt <= cnt + 1'b1;
                    if (!ra[0]) begin
                        ra <= ra >> 1;
                    end
                end
                LOOP: begin
                    cnt <= cnt + 1'b1;
                    if (rb_zero) begin
                        return_val <= ra << k;
                        cycles     <= cnt;
                        out_valid  <= 1'b1;
                    end else begin
                        ra <= ra_next;
                        rb <= rb_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_stream.sv
// Directed and randomised checks of gcd_stream at WIDTH=32 and WIDTH=8.
module tb_gcd_stream;
    import gcd_pkg::*;

    localparam int W_A  = 32;
    localparam int W_B  = 8;
    localparam int CW_A = $clog2(gcd_lat_max(W_A) + 4);
    localparam int CW_B = $clog2(gcd_lat_max(W_B) + 4);

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    logic            in_valid_32 = 1'b0;
    logic            in_ready_32;
    logic [W_A-1:0]  a_32 = '0;
    logic [W_A-1:0]  b_32 = '0;
    logic            out_valid_32;
    logic            out_ready_32 = 1'b0;
    logic [W_A-1:0]  return_val_32;
    logic [CW_A-1:0] cycles_32;
    logic            busy_32;

    logic            in_valid_8 = 1'b0;
    logic            in_ready_8;
    logic [W_B-1:0]  a_8 = '0;
    logic [W_B-1:0]  b_8 = '0;
    logic            out_valid_8;
    logic            out_ready_8 = 1'b0;
    logic [W_B-1:0]  return_val_8;
    logic [CW_B-1:0] cycles_8;
    logic            busy_8;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    gcd_stream #(.WIDTH(W_A)) dut_32 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .in_valid   (in_valid_32),
        .in_ready   (in_ready_32),
        .a          (a_32),
        .b          (b_32),
        .out_valid  (out_valid_32),
        .out_ready  (out_ready_32),
        .return_val (return_val_32),
        .cycles     (cycles_32),
        .busy       (busy_32)
    );

    gcd_stream #(.WIDTH(W_B)) dut_8 (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .in_valid   (in_valid_8),
        .in_ready   (in_ready_8),
        .a          (a_8),
        .b          (b_8),
        .out_valid  (out_valid_8),
        .out_ready  (out_ready_8),
        .return_val (return_val_8),
        .cycles     (cycles_8),
        .busy       (busy_8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Euclid by remainder, deliberately unlike the engine's shift/subtract method.
    function automatic logic [63:0] refGcd(input logic [63:0] x_in, input logic [63:0] y_in);
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] t;
        x = x_in;
        y = y_in;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic applyStimulus32(input logic [W_A-1:0] av, input logic [W_A-1:0] bv,
                                   input int vdelay, input int rdelay, input bit noise,
                                   output logic [W_A-1:0] res, output logic [CW_A-1:0] cyc);
        int n;
        repeat (vdelay) tick();
        in_valid_32 = 1'b1;
        a_32 = av;
        b_32 = bv;
        n = 0;
        while (!in_ready_32 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("accept32", in_ready_32, 1);
        tick();
        in_valid_32 = noise;
        a_32 = $urandom;
        b_32 = $urandom;
        n = 0;
        while (!out_valid_32 && n < gcd_lat_max(W_A) + 10) begin
            tick();
            if (noise) begin
                in_valid_32 = 1'($urandom_range(0, 1));
                a_32 = $urandom;
                b_32 = $urandom;
            end
            n++;
        end
        in_valid_32 = 1'b0;
        checkOutput("done32", out_valid_32, 1);
        res = return_val_32;
        cyc = cycles_32;
        repeat (rdelay) begin
            tick();
            if (noise) begin
                in_valid_32 = 1'($urandom_range(0, 1));
                a_32 = $urandom;
                b_32 = $urandom;
            end
        end
        in_valid_32 = 1'b0;
        if (rdelay > 0) begin
            checkOutput("hold_val32", return_val_32, res);
            checkOutput("hold_cyc32", cycles_32, cyc);
            checkOutput("hold_flags32", {out_valid_32, in_ready_32, busy_32}, 3'b101);
        end
        out_ready_32 = 1'b1;
        tick();
        out_ready_32 = 1'b0;
        checkOutput("release32", {out_valid_32, in_ready_32, busy_32}, 3'b010);
    endtask

    task automatic applyStimulus8(input logic [W_B-1:0] av, input logic [W_B-1:0] bv,
                                  input int vdelay, input int rdelay,
                                  output logic [W_B-1:0] res, output logic [CW_B-1:0] cyc);
        int n;
        repeat (vdelay) tick();
        in_valid_8 = 1'b1;
        a_8 = av;
        b_8 = bv;
        checkOutput("accept8", in_ready_8, 1);
        tick();
        n = 0;
        while (!out_valid_8 && n < gcd_lat_max(W_B) + 10) begin
            in_valid_8 = 1'($urandom_range(0, 1));
            a_8 = 8'($urandom);
            b_8 = 8'($urandom);
            tick();
            n++;
        end
        in_valid_8 = 1'b0;
        checkOutput("done8", out_valid_8, 1);
        res = return_val_8;
        cyc = cycles_8;
        repeat (rdelay) tick();
        checkOutput("hold_val8", return_val_8, res);
        out_ready_8 = 1'b1;
        tick();
        out_ready_8 = 1'b0;
        checkOutput("release8", {out_valid_8, in_ready_8}, 2'b01);
    endtask

    task automatic directed32(input string tag, input logic [W_A-1:0] av, input logic [W_A-1:0] bv,
                              input logic [W_A-1:0] expect_val);
        logic [W_A-1:0]  res;
        logic [CW_A-1:0] cyc;
        applyStimulus32(av, bv, 0, 0, 1'b0, res, cyc);
        checkOutput({tag, "_val"}, res, expect_val);
        checkOutput({tag, "_lat"}, 64'(cyc <= CW_A'(gcd_lat_max(W_A))), 1);
    endtask

    initial begin
        logic [W_A-1:0]  res32;
        logic [CW_A-1:0] cyc32;
        logic [W_B-1:0]  res8;
        logic [CW_B-1:0] cyc8;
        logic [W_A-1:0]  ra32;
        logic [W_A-1:0]  rb32;
        logic [W_B-1:0]  ra8;
        logic [W_B-1:0]  rb8;

        repeat (3) tick();
        checkOutput("reset_flags", {in_ready_32, out_valid_32, busy_32}, 3'b100);
        checkOutput("reset_val", return_val_32, 0);
        checkOutput("reset_cyc", cycles_32, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();

        $display("[TB] basic 28,42");
        applyStimulus32(32'd28, 32'd42, 0, 0, 1'b0, res32, cyc32);
        checkOutput("basic_val", res32, 14);
        checkOutput("basic_cyc", cyc32, 8);

        $display("[TB] zero operands");
        applyStimulus32(32'd0, 32'd17, 0, 0, 1'b0, res32, cyc32);
        checkOutput("zero_a_val", res32, 17);
        checkOutput("zero_a_cyc", cyc32, 1);
        applyStimulus32(32'd17, 32'd0, 1, 0, 1'b0, res32, cyc32);
        checkOutput("zero_b_val", res32, 17);
        checkOutput("zero_b_cyc", cyc32, 1);
        applyStimulus32(32'd0, 32'd0, 0, 0, 1'b0, res32, cyc32);
        checkOutput("zero_ab_val", res32, 0);
        checkOutput("zero_ab_cyc", cyc32, 1);

        $display("[TB] boundary operands");
        directed32("pow2", 32'h8000_0000, 32'hC000_0000, 32'h4000_0000);
        directed32("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
        directed32("equal", 32'd1001, 32'd1001, 32'd1001);
        directed32("coprime", 32'd1, 32'h8000_0000, 32'd1);

        $display("[TB] back-pressure hold with ignored input");
        applyStimulus32(32'd270, 32'd192, 0, 10, 1'b1, res32, cyc32);
        checkOutput("hold_result", res32, 6);

        $display("[TB] reset mid-operation");
        in_valid_32 = 1'b1;
        a_32 = 32'hFFFF_FFFF;
        b_32 = 32'hFFFF_FFFE;
        tick();
        in_valid_32 = 1'b0;
        repeat (5) tick();
        checkOutput("midop_busy", busy_32, 1);
        #3;
        sys_rst_n = 1'b0;
        #1;
        checkOutput("rst_flags", {in_ready_32, out_valid_32, busy_32}, 3'b100);
        checkOutput("rst_val", return_val_32, 0);
        checkOutput("rst_cyc", cycles_32, 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        tick();
        checkOutput("post_rst_ready", in_ready_32, 1);
        applyStimulus32(32'd12, 32'd18, 0, 0, 1'b0, res32, cyc32);
        checkOutput("post_rst_val", res32, 6);

        $display("[TB] random WIDTH=32");
        for (int i = 0; i < 150; i++) begin
            ra32 = $urandom << $urandom_range(0, 12);
            rb32 = $urandom << $urandom_range(0, 12);
            if (i % 23 == 0) ra32 = '0;
            if (i % 29 == 0) rb32 = '0;
            if (i % 11 == 0) rb32 = ra32 * 32'(($urandom_range(1, 3) * 2) + 1);
            applyStimulus32(ra32, rb32, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, res32, cyc32);
            checkOutput("rnd32_val", res32, refGcd(64'(ra32), 64'(rb32)));
            checkOutput("rnd32_lat", 64'(cyc32 <= CW_A'(gcd_lat_max(W_A))), 1);
        end

        $display("[TB] random WIDTH=8");
        for (int i = 0; i < 400; i++) begin
            ra8 = 8'($urandom);
            rb8 = 8'($urandom);
            if (i % 17 == 0) ra8 = '0;
            if (i % 19 == 0) rb8 = '0;
            applyStimulus8(ra8, rb8, $urandom_range(0, 3), $urandom_range(0, 3), res8, cyc8);
            checkOutput("rnd8_val", res8, refGcd(64'(ra8), 64'(rb8)));
            checkOutput("rnd8_lat", 64'(cyc8 <= CW_B'(gcd_lat_max(W_B))), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
